muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide stage. Sits directly downstream of the register unit.
//  - op_a/op_b are fed from output_rs1/output_rs2.
//  - result/rd_out/RUWr go back to the register unit write port.

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [RD_W-1:0] rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out,
  output logic            RUWr
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic [RD_W-1:0]   rd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   m_q;
  logic              sa_q;
  logic              sb_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   res_q;
  logic [RD_W-1:0]   rdo_q;

  logic            is_div;
  logic            sgn_a;
  logic            sgn_b;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] spec_res;

  assign is_div = funct3[2];
  assign sgn_a  = is_div ? ~funct3[0]
                         : (funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10);
  assign sgn_b  = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign neg_a  = sgn_a & op_a[XLEN-1];
  assign neg_b  = sgn_b & op_b[XLEN-1];
  assign mag_a  = neg_a ? -op_a : op_a;
  assign mag_b  = neg_b ? -op_b : op_b;
  assign div0   = is_div & (op_b == '0);
  assign ovf    = is_div & ~funct3[0] & (op_a == MINV) & (&op_b);
  assign spec_res = div0 ? (funct3[1] ? op_a : '1)
                         : (funct3[1] ? '0 : MINV);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fmag;
  logic [2*XLEN-1:0] fprod;
  logic [XLEN-1:0]   fast_res;
  assign fmag  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fprod = (neg_a ^ neg_b) ? -fmag : fmag;
  assign fast_res = (funct3[1:0] == 2'b00) ? fprod[XLEN-1:0]
                                           : fprod[2*XLEN-1:XLEN];
`endif

  // One iteration: multiply adds then shifts right, divide shifts left then trials.
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     trial;

  always_comb begin
    sum   = '0;
    trial = '0;
    acc_d = acc_q;
    if (!f3_q[2]) begin
      sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
      acc_d = {sum, acc_q[XLEN-1:1]};
    end else begin
      trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, m_q};
      if (!trial[XLEN])
        acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin;

  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -acc_d : acc_d;
    quo    = acc_d[XLEN-1:0];
    rem    = acc_d[2*XLEN-1:XLEN];
    fin    = '0;
    unique case (1'b1)
      (f3_q == 3'b000):                 fin = prod_s[XLEN-1:0];
      (!f3_q[2] && f3_q[1:0] != 2'b00): fin = prod_s[2*XLEN-1:XLEN];
      (f3_q[2] && !f3_q[1]):            fin = (sa_q ^ sb_q) ? -quo : quo;
      (f3_q[2] && f3_q[1]):             fin = sa_q ? -rem : rem;
      default:                          fin = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      rdo_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            f3_q   <= funct3;
            rd_q   <= rd_in;
            sa_q   <= neg_a;
            sb_q   <= neg_b;
            acc_q  <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
            m_q    <= is_div ? mag_b : mag_a;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (div0 || ovf) begin
              res_q   <= spec_res;
              rdo_q   <= rd_in;
              done_q  <= 1'b1;
              state_q <= DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div) begin
              res_q   <= fast_res;
              rdo_q   <= rd_in;
              done_q  <= 1'b1;
              state_q <= DONE;
`endif
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) begin
            res_q   <= fin;
            rdo_q   <= rd_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign RUWr   = done_q;
  assign result = res_q;
  assign rd_out = rdo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        RUWr;

  muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .RUWr(RUWr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = '0;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin p = sa / sb; r = p[31:0]; end
      3'd5: if (b == 0) r = '1; else begin p = ua / ub; r = p[31:0]; end
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else begin p = sa % sb; r = p[31:0]; end
      default: if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end
    endcase
    return r;
  endfunction

  // Edges from the strobe edge (E0) to the edge that raises done, counting E0.
  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL idle_timeout: busy stuck at %b", busy);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res);
    exp_t e;
    @(posedge clk); #1;
    wait_idle();
    funct3 = f; op_a = a; op_b = b; rd_in = rd;
    start  = 1'b1;
    e.res = exp_res; e.rd = rd; e.lat = lat_of(f, a, b); e.t0 = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the unit reports a result.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done || RUWr) chk("ruwr_eq_done", {31'b0, RUWr}, {31'b0, done});
      if (done) begin
        chk("done_single", {31'b0, prev_done}, 32'h0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: result %h, expected no done", result);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
          chk("latency", cyc - e.t0, e.lat);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   {31'b0, busy}, 32'h0);
    chk("rst_done",   {31'b0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_rd",     {27'b0, rd_out}, 32'h0);
    rst = 1'b0;

    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    issue(3'b101, 32'd100, 32'd7, 5'd7, 32'd14);
    issue(3'b111, 32'd100, 32'd7, 5'd8, 32'd2);
    issue(3'b100, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
    issue(3'b111, 32'd5, 32'd0, 5'd10, 32'd5);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h0);
    issue(3'b000, 32'd6, 32'd7, 5'd12, 32'd42);

    // Start pulse mid-iteration must not disturb the running op.
    issue(3'b000, 32'd123, 32'd456, 5'd13, 32'd56088);
    repeat (9) @(posedge clk);
    #1;
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd30;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Reset mid-iteration aborts without a write-back.
    issue(3'b101, 32'd5000, 32'd7, 5'd14, 32'd714);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("abort_busy",   {31'b0, busy}, 32'h0);
    chk("abort_done",   {31'b0, done}, 32'h0);
    chk("abort_ruwr",   {31'b0, RUWr}, 32'h0);
    chk("abort_result", result, 32'h0);
    chk("abort_rd",     {27'b0, rd_out}, 32'h0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    issue(3'b101, 32'd9, 32'd3, 5'd15, 32'd3);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(f, a, b, 5'($urandom_range(0, 31)), ref_op(f, a, b));
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
